// File: rtl/toffoli_cascade.sv
// toffoli_cascade: STAGES-deep pipelined cascade of configurable (multi-)controlled Toffoli gates.
// Define TOFFOLI_CASCADE_INV_EN to let each word run the cascade in reverse order via in_inv.
module toffoli_cascade #(
  parameter int WIDTH = 3,
  parameter int STAGES = 4,
  localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int TW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic             cfg_en,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [TW-1:0]    cfg_tgt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  logic [STAGES-1:0][WIDTH-1:0] data_q, data_d, src_data, mask_q, mask_d;
  logic [STAGES-1:0][TW-1:0]    tgt_q, tgt_d;
  logic [STAGES-1:0]            vld_q, vld_d, src_vld, sinv, en_q, en_d;
  logic                         stall, wr;

  // The target bit never controls itself; an empty control set flips the target unconditionally.
  function automatic logic [WIDTH-1:0] gate(input logic [WIDTH-1:0] d, input logic en,
                                            input logic [WIDTH-1:0] m, input logic [TW-1:0] t);
    logic [WIDTH-1:0] ctl;
    logic             hit;
    ctl = m & ~(WIDTH'(1) << t);
    hit = en && (32'(t) < WIDTH) && (&(d | ~ctl));
    return d ^ (WIDTH'(hit) << t);
  endfunction

  function automatic int sel(input int k, input logic inv);
    return inv ? STAGES - 1 - k : k;
  endfunction

  always_comb begin
    src_data[0] = in_data;
    src_vld[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_data[k] = data_q[k-1];
      src_vld[k]  = vld_q[k-1];
    end
  end

`ifdef TOFFOLI_CASCADE_INV_EN
  logic [STAGES-1:0] inv_q, inv_d;
  always_comb begin
    sinv[0] = in_inv;
    for (int k = 1; k < STAGES; k++) sinv[k] = inv_q[k-1];
    inv_d = stall ? inv_q : sinv;
  end
  always_ff @(posedge clk) inv_q <= rst ? '0 : inv_d;
`else
  logic unused_inv;
  assign unused_inv = in_inv;
  assign sinv = '0;
`endif

  always_comb begin
    stall = vld_q[STAGES-1] & ~out_ready;
    wr    = cfg_we & ~busy & ~in_valid;
    vld_d = stall ? vld_q : src_vld;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = stall ? data_q[k] : gate(src_data[k], en_q[sel(k, sinv[k])],
                                           mask_q[sel(k, sinv[k])], tgt_q[sel(k, sinv[k])]);
      en_d[k]   = (wr && 32'(cfg_idx) == k) ? cfg_en : en_q[k];
      mask_d[k] = (wr && 32'(cfg_idx) == k) ? cfg_mask : mask_q[k];
      tgt_d[k]  = (wr && 32'(cfg_idx) == k) ? cfg_tgt : tgt_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
      en_q   <= '0;
      mask_q <= '0;
      tgt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      en_q   <= en_d;
      mask_q <= mask_d;
      tgt_q  <= tgt_d;
    end
  end

  assign busy      = |vld_q;
  assign in_ready  = ~stall;
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
endmodule

// File: doc/toffoli_cascade.md
TOFFOLI_CASCADE -- requirements
Module: toffoli_cascade

Interface
REQ-001 Parameter WIDTH, default 3: number of reversible lines, range 2..32; line 0 = A, line 1 = B, line 2 = C.
REQ-002 Parameter STAGES, default 4: number of gate stages, range 1..16; one pipeline register per stage.
REQ-003 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port cfg_we  in  1  configuration write strobe.
REQ-006 Port cfg_idx  in  max(1,$clog2(STAGES))  stage index written.
REQ-007 Port cfg_en  in  1  stage enable; 0 = identity stage.
REQ-008 Port cfg_mask  in  WIDTH  control-line mask.
REQ-009 Port cfg_tgt  in  max(1,$clog2(WIDTH))  target-line index.
REQ-010 Port in_valid  in  1  input word valid.
REQ-011 Port in_ready  out  1  cascade accepts the input word.
REQ-012 Port in_data  in  WIDTH  input line values.
REQ-013 Port in_inv  in  1  1 = apply inverse cascade to this word.
REQ-014 Port out_valid  out  1  output word valid.
REQ-015 Port out_ready  in  1  downstream accepts the output word.
REQ-016 Port out_data  out  WIDTH  transformed line values.
REQ-017 Port busy  out  1  any pipeline stage holds a valid word.

Function
REQ-018 Stage op: t = AND of data bits selected by (mask with target bit cleared); data[tgt] ^= t; all other bits pass unchanged.
REQ-019 Empty effective mask gives t = 1 (NOT gate); one bit = CNOT; two bits = Toffoli; more = multi-controlled Toffoli.
REQ-020 cfg_tgt >= WIDTH makes the stage identity.
REQ-021 Forward word: pipeline stage k applies config k.
REQ-022 Inverse word: pipeline stage k applies config STAGES-1-k.
REQ-023 The inv flag travels with its word, so forward and inverse words mix freely in flight.
REQ-024 Latency: exactly STAGES cycles from the accept edge to out_valid, absent stalls.
REQ-025 Throughput: one word per cycle.
REQ-026 Transfer occurs when valid && ready on the same edge.
REQ-027 Stall = out_valid && !out_ready; a stall freezes every stage (data, valid, inv).
REQ-028 in_ready = !stall, combinational.
REQ-029 out_data is held stable while out_valid && !out_ready.
REQ-030 cfg_we is honoured only when busy=0 and in_valid=0; otherwise the write is ignored.
REQ-031 A config write takes effect for words accepted on later cycles.
REQ-032 Simultaneous input accept and output drain with a full pipe: both transfers occur with no bubble.

Reset
REQ-033 rst (sampled at the clk edge) clears all stage valid bits and all stage configs (cfg_en = 0).
REQ-034 Reset values: out_valid = 0, out_data = 0, busy = 0, in_ready = 1.
REQ-035 Reset mid-operation discards in-flight words; none is ever emitted.
REQ-036 rst has priority over cfg_we and input transfers in the same cycle.

Configuration
REQ-037 Macro TOFFOLI_CASCADE_INV_EN defined: in_inv is honoured per REQ-022.
REQ-038 Macro TOFFOLI_CASCADE_INV_EN undefined: in_inv is ignored, all words run forward, and no inv flag is stored.

Verification
REQ-039 Reset, then word 3'b101 with all stages disabled -> out 3'b101 after exactly 4 cycles.
REQ-040 Stage 0 = {mask 3'b011, tgt 2}, in 3'b011 -> 3'b111; in 3'b111 -> 3'b011; in 3'b001 -> 3'b001.
REQ-041 Stages 0..3 = Toffoli(t2), CNOT(0->1), NOT(0), CNOT(2->0): forward of each of the 8 values, then inverse of the result, returns the original value (with INV_EN).
REQ-042 out_ready held low 3 cycles with a full pipe -> out_data stable, in_ready = 0, no word lost or duplicated; 8 back-to-back words emerge in order.
REQ-043 cfg_we while busy = 1 -> config unchanged; cfg_mask 3'b111 with tgt 2 behaves as mask 3'b011.
REQ-044 rst asserted with 2 words in flight -> out_valid stays 0 and busy = 0 on the next cycle; all configs read back as identity.
